nn_stage_sequencer: RTL and testbench

Parametrised inference controller that drives a chain of NUM_STAGES pipeline engines (flatten, fully-connected layers, relu, argmax, …) through level start / done handshakes and returns the final class index. It sits at the top of the MNIST datapath. It generalises the fixed five-step sequencer in three ways: the stage count is a parameter, the block is re-runnable back-to-back, and it adds abort, a per-stage watchdog and a latency counter.

---
 rtl/nn_stage_sequencer_if.sv | 29 ++
 rtl/nn_stage_sequencer.sv | 129 ++++++++++++
 tb/tb_nn_stage_sequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/nn_stage_sequencer_if.sv
// Request / stage-engine bus of the inference stage sequencer.
// The slave modport is the sequencer; the master modport is the host plus the engine chain.
interface nn_stage_sequencer_if #(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned RESULT_W   = 4,
  parameter int unsigned CNT_W      = 24
);
  logic                  start;
  logic                  abort;
  logic                  busy;
  logic [NUM_STAGES-1:0] stage_start;
  logic [NUM_STAGES-1:0] stage_done;
  logic [RESULT_W-1:0]   stage_result;
  logic [RESULT_W-1:0]   result;
  logic                  result_valid;
  logic                  error;
  logic [3:0]            err_stage;
  logic [CNT_W-1:0]      last_latency;

  modport master (
    output start, abort, stage_done, stage_result,
    input  busy, stage_start, result, result_valid, error, err_stage, last_latency
  );

  modport slave (
    input  start, abort, stage_done, stage_result,
    output busy, stage_start, result, result_valid, error, err_stage, last_latency
  );
endinterface

// File: rtl/nn_stage_sequencer.sv
// Sequences NUM_STAGES engines through level start/done handshakes, one idle gap cycle
// between stages, with abort, per-stage watchdog and run-latency measurement.
module nn_stage_sequencer #(
  parameter int unsigned NUM_STAGES     = 4,
  parameter int unsigned RESULT_W       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter int unsigned CNT_W          = 24
) (
  input logic                clk,
  input logic                reset,
  nn_stage_sequencer_if.slave bus
);

  localparam int unsigned     IDX_W    = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam bit               WD_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t                state;
  logic [IDX_W-1:0]      idx;
  logic [NUM_STAGES-1:0] stage_start_q;
  logic                  busy_q;
  logic [RESULT_W-1:0]   result_q;
  logic                  result_valid_q;
  logic                  error_q;
  logic [3:0]            err_stage_q;
  logic [CNT_W-1:0]      wdog;
  logic [CNT_W-1:0]      lat;
  logic [CNT_W-1:0]      last_latency_q;
  logic                  active_done;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Only the done bit of the stage currently being started is honoured.
  assign active_done = |(bus.stage_done & stage_start_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      idx            <= '0;
      stage_start_q  <= '0;
      busy_q         <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      error_q        <= 1'b0;
      err_stage_q    <= '0;
      wdog           <= '0;
      lat            <= '0;
      last_latency_q <= '0;
    end else begin
      result_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            state         <= S_RUN;
            idx           <= '0;
            stage_start_q <= NUM_STAGES'(1);
            busy_q        <= 1'b1;
            error_q       <= 1'b0;
            err_stage_q   <= '0;
            wdog          <= '0;
            lat           <= CNT_W'(1);
          end
        end
        S_RUN: begin
          lat  <= sat_inc(lat);
          wdog <= sat_inc(wdog);
          if (bus.abort) begin
            state         <= S_IDLE;
            stage_start_q <= '0;
            busy_q        <= 1'b0;
          end else if (active_done) begin
            stage_start_q <= '0;
            if (idx == LAST_IDX) begin
              state          <= S_IDLE;
              busy_q         <= 1'b0;
              result_q       <= bus.stage_result;
              result_valid_q <= 1'b1;
              last_latency_q <= sat_inc(lat);
            end else begin
              state <= S_GAP;
            end
          end else if (WD_EN && (wdog >= WD_LIMIT)) begin
            state         <= S_IDLE;
            stage_start_q <= '0;
            busy_q        <= 1'b0;
            error_q       <= 1'b1;
            err_stage_q   <= idx;
          end
        end
        S_GAP: begin
          lat  <= sat_inc(lat);
          wdog <= '0;
          if (bus.abort) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end else begin
            state         <= S_RUN;
            idx           <= idx + IDX_W'(1);
            stage_start_q <= NUM_STAGES'(1) << (idx + IDX_W'(1));
          end
        end
        default: begin
          state         <= S_IDLE;
          stage_start_q <= '0;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.stage_start  = stage_start_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.error        = error_q;
  assign bus.err_stage    = err_stage_q;
  assign bus.last_latency = last_latency_q;

endmodule

// File: tb/tb_nn_stage_sequencer.sv
// Directed per-cycle vector bench for nn_stage_sequencer (3 stages, 10-cycle watchdog).
module tb_nn_stage_sequencer;

  localparam int unsigned NS  = 3;
  localparam int unsigned RW  = 4;
  localparam int unsigned CW  = 24;
  localparam int unsigned TMO = 10;

  typedef struct {
    logic          st;
    logic          ab;
    logic [NS-1:0] dn;
    logic [RW-1:0] sr;
    logic [NS-1:0] e_ss;
    logic          e_busy;
    logic          e_rv;
    logic [RW-1:0] e_res;
    logic          e_err;
    logic [3:0]    e_es;
    logic [CW-1:0] e_lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  nn_stage_sequencer_if #(.NUM_STAGES(NS), .RESULT_W(RW), .CNT_W(CW)) bus ();

  nn_stage_sequencer #(
    .NUM_STAGES(NS), .RESULT_W(RW), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Row = inputs applied during a cycle and the outputs expected during that same cycle.
  function automatic void add(int st, int ab, int dn, int sr,
                              int ss, int b, int rv, int res, int er, int es, int lat);
    vec_t v;
    v.st = 1'(st);     v.ab = 1'(ab);        v.dn = NS'(dn);    v.sr = RW'(sr);
    v.e_ss = NS'(ss);  v.e_busy = 1'(b);     v.e_rv = 1'(rv);   v.e_res = RW'(res);
    v.e_err = 1'(er);  v.e_es = 4'(es);      v.e_lat = CW'(lat);
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({bus.stage_start, bus.busy, bus.result_valid, bus.result,
                bus.error, bus.err_stage, bus.last_latency});
  endfunction

  initial begin
    int  hi_cnt;
    bit  seen_err;
    bit  seen_rv;

    // reset state
    add(0,0,0,0, 0,0,0,0,0,0,0);
    // basic run, each stage done on its first RUN cycle, result 7
    add(1,0,0,0, 0,0,0,0,0,0,0);
    add(0,0,1,0, 1,1,0,0,0,0,0);
    add(0,0,0,0, 0,1,0,0,0,0,0);
    add(0,0,2,0, 2,1,0,0,0,0,0);
    add(0,0,0,0, 0,1,0,0,0,0,0);
    add(0,0,4,7, 4,1,0,0,0,0,0);
    add(0,0,0,0, 0,0,1,7,0,0,6);
    add(0,0,0,0, 0,0,0,7,0,0,6);
    // back-to-back with start held high; second run stage 0 takes two cycles
    add(1,0,0,0, 0,0,0,7,0,0,6);
    add(1,0,1,0, 1,1,0,7,0,0,6);
    add(1,0,0,0, 0,1,0,7,0,0,6);
    add(1,0,2,0, 2,1,0,7,0,0,6);
    add(1,0,0,0, 0,1,0,7,0,0,6);
    add(1,0,4,3, 4,1,0,7,0,0,6);
    add(1,0,0,0, 0,0,1,3,0,0,6);
    add(1,0,0,0, 1,1,0,3,0,0,6);
    add(1,0,1,0, 1,1,0,3,0,0,6);
    add(1,0,0,0, 0,1,0,3,0,0,6);
    add(1,0,2,0, 2,1,0,3,0,0,6);
    add(1,0,0,0, 0,1,0,3,0,0,6);
    add(1,0,4,9, 4,1,0,3,0,0,6);
    add(0,0,0,0, 0,0,1,9,0,0,7);
    // watchdog in stage 1, noise on the other done bits
    add(1,0,0,0, 0,0,0,9,0,0,7);
    add(0,0,1,0, 1,1,0,9,0,0,7);
    add(0,0,0,0, 0,1,0,9,0,0,7);
    for (int i = 0; i < 10; i++) add(0,0,5,0, 2,1,0,9,0,0,7);
    add(0,0,0,0, 0,0,0,9,1,1,7);
    add(1,0,0,0, 0,0,0,9,1,1,7);
    add(0,1,0,0, 1,1,0,9,0,0,7);
    // done on exactly the 10th RUN cycle of stage 1
    add(1,0,0,0, 0,0,0,9,0,0,7);
    add(0,0,1,0, 1,1,0,9,0,0,7);
    add(0,0,0,0, 0,1,0,9,0,0,7);
    for (int i = 0; i < 9; i++) add(0,0,0,0, 2,1,0,9,0,0,7);
    add(0,0,2,0, 2,1,0,9,0,0,7);
    add(0,0,0,0, 0,1,0,9,0,0,7);
    add(0,0,4,5, 4,1,0,9,0,0,7);
    add(0,0,0,0, 0,0,1,5,0,0,15);
    // abort in GAP(0), then done[1] with abort in RUN(1), then start+abort in IDLE
    add(1,0,0,0, 0,0,0,5,0,0,15);
    add(0,0,1,0, 1,1,0,5,0,0,15);
    add(0,1,0,0, 0,1,0,5,0,0,15);
    add(1,0,0,0, 0,0,0,5,0,0,15);
    add(0,0,1,0, 1,1,0,5,0,0,15);
    add(0,0,0,0, 0,1,0,5,0,0,15);
    add(0,1,2,12, 2,1,0,5,0,0,15);
    add(1,1,0,0, 0,0,0,5,0,0,15);
    add(0,0,0,0, 0,0,0,5,0,0,15);
    // spurious done[2] and starts while busy
    add(1,0,0,0, 0,0,0,5,0,0,15);
    add(0,0,5,0, 1,1,0,5,0,0,15);
    add(1,0,4,0, 0,1,0,5,0,0,15);
    add(1,0,6,0, 2,1,0,5,0,0,15);
    add(0,0,4,0, 0,1,0,5,0,0,15);
    add(0,0,4,7, 4,1,0,5,0,0,15);
    add(0,0,0,0, 0,0,1,7,0,0,6);

    reset = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.stage_done = '0; bus.stage_result = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.stage_start !== tbl[i].e_ss || bus.busy !== tbl[i].e_busy ||
          bus.result_valid !== tbl[i].e_rv || bus.result !== tbl[i].e_res ||
          bus.error !== tbl[i].e_err || bus.err_stage !== tbl[i].e_es ||
          bus.last_latency !== tbl[i].e_lat) begin
        n_fail++;
        $display("FAIL row %0d: got ss=%b busy=%b rv=%b res=%0d err=%b es=%0d lat=%0d, expected ss=%b busy=%b rv=%b res=%0d err=%b es=%0d lat=%0d",
                 i, bus.stage_start, bus.busy, bus.result_valid, bus.result, bus.error,
                 bus.err_stage, bus.last_latency, tbl[i].e_ss, tbl[i].e_busy, tbl[i].e_rv,
                 tbl[i].e_res, tbl[i].e_err, tbl[i].e_es, tbl[i].e_lat);
      end
      bus.start        = tbl[i].st;
      bus.abort        = tbl[i].ab;
      bus.stage_done   = tbl[i].dn;
      bus.stage_result = tbl[i].sr;
    end

    // reset in the middle of a run clears everything including result and latency
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b0; bus.stage_done = '0; bus.stage_result = '0;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_before_reset", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("outputs_after_midrun_reset", all_outs(), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("outputs_idle_after_reset", all_outs(), 64'd0);

    // watchdog in stage 0, bounded wait for the error flag
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    hi_cnt = 0; seen_err = 1'b0; seen_rv = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.error) begin
        seen_err = 1'b1;
        break;
      end
      if (bus.stage_start[0]) hi_cnt++;
      if (bus.result_valid) seen_rv = 1'b1;
      @(negedge clk);
    end
    chk("wdog0_error_seen", 64'(seen_err), 64'd1);
    chk("wdog0_start_high_cycles", 64'(hi_cnt), 64'(TMO));
    chk("wdog0_err_stage", 64'(bus.err_stage), 64'd0);
    chk("wdog0_no_result_valid", 64'(seen_rv), 64'd0);
    chk("wdog0_busy_low", 64'(bus.busy), 64'd0);
    chk("wdog0_stage_start_low", 64'(bus.stage_start), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
